// File: rtl/byte_splitter_if.sv
// Word-in / byte-lanes-out handshake bundle for byte_splitter.
// The producer/consumer side (master) drives A, swap, in_valid and
// out_ready; the splitter side (slave) drives the lanes, flags and in_ready.
interface byte_splitter_if;
  logic [31:0] A;
  logic        in_valid;
  logic        in_ready;
  logic        swap;
  logic [7:0]  O1;
  logic [7:0]  O2;
  logic [7:0]  O3;
  logic [7:0]  O4;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  zero_mask;
  logic        neg;

  modport master (
    output A, in_valid, swap, out_ready,
    input  in_ready, O1, O2, O3, O4, out_valid, zero_mask, neg
  );

  modport slave (
    input  A, in_valid, swap, out_ready,
    output in_ready, O1, O2, O3, O4, out_valid, zero_mask, neg
  );
endinterface

// File: rtl/byte_splitter.sv
// Registered 32-bit word to four 8-bit lane splitter with optional
// byte-swap, one-deep valid/ready output stage and per-lane zero flags.
// Lane index 0 corresponds to O1 (MSB lane in the default order).
module byte_splitter #(
  parameter logic [7:0] RESET_BYTE = 8'h00
) (
  input logic           clk,
  input logic           rst_n,
  byte_splitter_if.slave bus
);

  logic [3:0][7:0] lane_reg;
  logic [3:0][7:0] lane_next;
  logic [3:0]      zero_reg;
  logic [3:0]      zero_next;
  logic            neg_reg;
  logic            valid_reg;
  logic            ready_w;
  logic            accept_w;

  // The stage can take a word when empty or when its current word leaves now.
  assign ready_w  = !valid_reg || bus.out_ready;
  assign accept_w = bus.in_valid && ready_w;

  // Pure bit selection per lane: swap mirrors the byte order, no extension.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_next[gi] = bus.swap ? bus.A[8*gi +: 8]
                                      : bus.A[31-8*gi -: 8];
      assign zero_next[gi] = (lane_next[gi] == 8'h00);
    end
  endgenerate

  // Output stage: load on accept, drop valid when taken without a refill,
  // otherwise hold everything stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_reg  <= {4{RESET_BYTE}};
      zero_reg  <= {4{RESET_BYTE == 8'h00}};
      neg_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else if (accept_w) begin
      lane_reg  <= lane_next;
      zero_reg  <= zero_next;
      neg_reg   <= bus.A[31];
      valid_reg <= 1'b1;
    end else if (valid_reg && bus.out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = ready_w;
  assign bus.out_valid = valid_reg;
  assign bus.O1        = lane_reg[0];
  assign bus.O2        = lane_reg[1];
  assign bus.O3        = lane_reg[2];
  assign bus.O4        = lane_reg[3];
  assign bus.zero_mask = zero_reg;
  assign bus.neg       = neg_reg;

endmodule

// File: tb/tb_byte_splitter.sv
// Directed self-checking bench for byte_splitter. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_byte_splitter;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  byte_splitter_if bus ();

  byte_splitter #(.RESET_BYTE(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes();
    return {bus.O1, bus.O2, bus.O3, bus.O4};
  endfunction

  // Check lanes, flags and valid in one go.
  task automatic check_out(input string tag, input logic [31:0] l, input logic [3:0] zm,
                           input logic n, input logic v);
    check({tag, ".lanes"}, lanes(), l);
    check({tag, ".zero_mask"}, {28'd0, bus.zero_mask}, {28'd0, zm});
    check({tag, ".neg"}, {31'd0, bus.neg}, {31'd0, n});
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n        = 1'b1;
    bus.A        = 32'hFEFCF8F0;
    bus.in_valid = 1'b1;
    bus.swap     = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset held with a valid word on the input.
    step(); step();
    check_out("reset", 32'h00000000, 4'b1111, 1'b0, 1'b0);
    check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    $display("step reset: lanes=%h zm=%b", lanes(), bus.zero_mask);

    // Release mid-cycle; first edge afterwards accepts the word.
    rst_n = 1'b1;
    step();
    check_out("basic", 32'hFEFCF8F0, 4'b0000, 1'b1, 1'b1);
    $display("step basic: lanes=%h", lanes());

    // Byte swap of the same word.
    bus.swap = 1'b1;
    step();
    check_out("swap", 32'hF0F8FCFE, 4'b0000, 1'b1, 1'b1);
    $display("step swap: lanes=%h", lanes());

    // Zero lanes in positions O1 and O3.
    bus.swap = 1'b0;
    bus.A    = 32'h00120034;
    step();
    check_out("zero", 32'h00120034, 4'b0101, 1'b0, 1'b1);
    $display("step zero: lanes=%h zm=%b", lanes(), bus.zero_mask);

    // Capture 0x11223344, then stall three cycles with a new word waiting.
    bus.A = 32'h11223344;
    step();
    check("bp.capture", lanes(), 32'h11223344);
    bus.out_ready = 1'b0;
    bus.A         = 32'h55667788;
    #1 check("bp.in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("bp.stall%0d", i), 32'h11223344, 4'b0000, 1'b0, 1'b1);
      check($sformatf("bp.stall%0d.in_ready", i), {31'd0, bus.in_ready}, 32'd0);
      $display("step stall%0d: lanes=%h in_ready=%b", i, lanes(), bus.in_ready);
    end
    bus.out_ready = 1'b1;
    #1 check("bp.in_ready_high", {31'd0, bus.in_ready}, 32'd1);
    step();
    check_out("bp.release", 32'h55667788, 4'b0000, 1'b0, 1'b1);
    $display("step release: lanes=%h", lanes());

    // Drain: taken with nothing new -> valid clears, data holds.
    bus.in_valid = 1'b0;
    bus.A        = 32'hDEADBEEF;
    step();
    check_out("drain", 32'h55667788, 4'b0000, 1'b0, 1'b0);
    $display("step drain: lanes=%h valid=%b", lanes(), bus.out_valid);

    // Idle cycle with in_valid low: nothing captured.
    step();
    check_out("idle", 32'h55667788, 4'b0000, 1'b0, 1'b0);

    // Capture a negative word with zero middle lanes, then stall.
    bus.in_valid = 1'b1;
    bus.A        = 32'h80000001;
    step();
    check_out("neg", 32'h80000001, 4'b0110, 1'b1, 1'b1);
    $display("step neg: lanes=%h zm=%b", lanes(), bus.zero_mask);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    check_out("hold", 32'h80000001, 4'b0110, 1'b1, 1'b1);

    // Asynchronous reset between edges clears outputs immediately.
    #2 rst_n = 1'b0;
    #1;
    check_out("async_rst", 32'h00000000, 4'b1111, 1'b0, 1'b0);
    check("async_rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    $display("step async_rst: lanes=%h valid=%b", lanes(), bus.out_valid);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
